// File: rtl/confreg_axi_bridge_pkg.sv
// Shared definitions for the confreg-to-AXI3 bridge: FSM states,
// fixed AXI attributes for single-beat word accesses, and default IDs.
package confreg_axi_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      AR,
      R,
      AW,
      W,
      B
   } state_t;

   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [3:0] LEN_1      = 4'd0;

   localparam int unsigned DEF_RD_ID = 1;
   localparam int unsigned DEF_WR_ID = 1;

endpackage

// File: rtl/confreg_axi_bridge_if.sv
// AXI3 master-side channel bundle (AR/R/AW/W/B) used by the confreg bridge.
interface confreg_axi_bridge_if #(
   parameter int ID_W = 4
);

   logic [ID_W-1:0] arid;
   logic [31:0]     araddr;
   logic [3:0]      arlen;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic [1:0]      arlock;
   logic [3:0]      arcache;
   logic [2:0]      arprot;
   logic            arvalid;
   logic            arready;

   logic [ID_W-1:0] rid;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rlast;
   logic            rvalid;
   logic            rready;

   logic [ID_W-1:0] awid;
   logic [31:0]     awaddr;
   logic [3:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic [1:0]      awlock;
   logic [3:0]      awcache;
   logic [2:0]      awprot;
   logic            awvalid;
   logic            awready;

   logic [ID_W-1:0] wid;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast;
   logic            wvalid;
   logic            wready;

   logic [ID_W-1:0] bid;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

endinterface

// File: rtl/confreg_axi_bridge.sv
// Converts the upstream single-word uncached/confreg request interface into
// single-beat AXI3 transactions, one outstanding at a time, writes first.
module confreg_axi_bridge
   import confreg_axi_bridge_pkg::*;
#(
   parameter int              ID_W  = 4,
   parameter logic [ID_W-1:0] RD_ID = ID_W'(DEF_RD_ID),
   parameter logic [ID_W-1:0] WR_ID = ID_W'(DEF_WR_ID)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   up_rd_req,
   input  logic [3:0]             up_wr_strb,
   input  logic [31:0]            up_addr,
   input  logic [31:0]            up_wdata,
   input  logic                   up_wvalid,
   input  logic                   up_wlast,
   output logic                   write_begin,
   output logic                   up_rvalid,
   output logic [ID_W-1:0]        up_rid,
   output logic                   up_rlast,
   output logic [31:0]            up_rdata,
   output logic                   up_wready,
   output logic                   up_bvalid,
   confreg_axi_bridge_if.master   axi
);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  strb_q;
   logic        rd_hit;
   logic        wr_hit;
   logic        unused_resp;

   assign rd_hit      = axi.rvalid && (axi.rid == RD_ID);
   assign wr_hit      = axi.bvalid && (axi.bid == WR_ID);
   assign unused_resp = ^{axi.rresp, axi.bresp};

   assign axi.arid    = RD_ID;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = LEN_1;
   assign axi.arsize  = SIZE_4B;
   assign axi.arburst = BURST_INCR;
   assign axi.arlock  = '0;
   assign axi.arcache = '0;
   assign axi.arprot  = '0;

   assign axi.awid    = WR_ID;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = LEN_1;
   assign axi.awsize  = SIZE_4B;
   assign axi.awburst = BURST_INCR;
   assign axi.awlock  = '0;
   assign axi.awcache = '0;
   assign axi.awprot  = '0;

   assign axi.wid     = WR_ID;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = strb_q;

   // Address and strobes are captured only when leaving IDLE, so they stay
   // stable through the address handshake even if upstream lets go early.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE) begin
            if (|up_wr_strb) begin
               addr_q <= up_addr;
               strb_q <= up_wr_strb;
            end else if (up_rd_req) begin
               addr_q <= up_addr;
            end
         end
         if (state == AW && axi.awready) begin
            wdata_q <= up_wdata;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      axi.wlast   = 1'b0;
      axi.bready  = 1'b0;
      write_begin = 1'b0;
      up_rvalid   = 1'b0;
      up_rid      = '0;
      up_rlast    = 1'b0;
      up_rdata    = '0;
      up_wready   = 1'b0;
      up_bvalid   = 1'b0;

      case (state)
         IDLE: begin
            if (|up_wr_strb) begin
               state_nxt = AW;
            end else if (up_rd_req) begin
               state_nxt = AR;
            end
         end
         AR: begin
            axi.arvalid = 1'b1;
            if (axi.arready) begin
               state_nxt = R;
            end
         end
         // Beats carrying a foreign RID are accepted and silently dropped.
         R: begin
            axi.rready = 1'b1;
            up_rvalid  = rd_hit;
            up_rid     = axi.rid;
            up_rlast   = axi.rlast;
            up_rdata   = axi.rdata;
            if (rd_hit && axi.rlast) begin
               state_nxt = IDLE;
            end
         end
         AW: begin
            axi.awvalid = 1'b1;
            if (axi.awready) begin
               write_begin = 1'b1;
               state_nxt   = W;
            end
         end
         W: begin
            axi.wvalid = up_wvalid;
            axi.wlast  = up_wlast;
            up_wready  = axi.wready;
            if (up_wvalid && axi.wready) begin
               state_nxt = B;
            end
         end
         B: begin
            axi.bready = 1'b1;
            if (wr_hit) begin
               up_bvalid = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_confreg_axi_bridge.sv
// Directed bench for confreg_axi_bridge: plays the AXI slave by hand and
// checks every handshake against hand-computed values.
module tb_confreg_axi_bridge;

   logic        clk;
   logic        rst;
   logic        up_rd_req;
   logic [3:0]  up_wr_strb;
   logic [31:0] up_addr;
   logic [31:0] up_wdata;
   logic        up_wvalid;
   logic        up_wlast;
   logic        write_begin;
   logic        up_rvalid;
   logic [3:0]  up_rid;
   logic        up_rlast;
   logic [31:0] up_rdata;
   logic        up_wready;
   logic        up_bvalid;

   int passCount  = 0;
   int checkCount = 0;

   confreg_axi_bridge_if #(.ID_W(4)) axi ();

   confreg_axi_bridge #(.ID_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .up_rd_req   (up_rd_req),
      .up_wr_strb  (up_wr_strb),
      .up_addr     (up_addr),
      .up_wdata    (up_wdata),
      .up_wvalid   (up_wvalid),
      .up_wlast    (up_wlast),
      .write_begin (write_begin),
      .up_rvalid   (up_rvalid),
      .up_rid      (up_rid),
      .up_rlast    (up_rlast),
      .up_rdata    (up_rdata),
      .up_wready   (up_wready),
      .up_bvalid   (up_bvalid),
      .axi         (axi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic [3:0] strb,
                                input logic [31:0] addr, input logic [31:0] data);
      up_rd_req  = rd;
      up_wr_strb = strb;
      up_addr    = addr;
      up_wdata   = data;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hard stop in case the stimulus sequence ever stalls.
   initial begin
      #20000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b0;
      up_wvalid = 1'b0;
      up_wlast  = 1'b0;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      axi.arready = 1'b0;
      axi.rid     = '0;
      axi.rdata   = '0;
      axi.rresp   = '0;
      axi.rlast   = 1'b0;
      axi.rvalid  = 1'b0;
      axi.awready = 1'b0;
      axi.wready  = 1'b0;
      axi.bid     = '0;
      axi.bresp   = '0;
      axi.bvalid  = 1'b0;

      #12;
      checkOutput("rst_arvalid", 32'(axi.arvalid), 32'd0);
      checkOutput("rst_awvalid", 32'(axi.awvalid), 32'd0);
      checkOutput("rst_awaddr", axi.awaddr, 32'h0);
      checkOutput("rst_wstrb", 32'(axi.wstrb), 32'h0);
      checkOutput("rst_arsize", 32'(axi.arsize), 32'h2);
      tick();
      rst = 1'b1;
      tick();

      $display("[TB] read with zero-wait slave");
      applyStimulus(1'b1, 4'h0, 32'h1000_0004, 32'h0);
      axi.arready = 1'b1;
      #1;
      checkOutput("rd_idle_arvalid", 32'(axi.arvalid), 32'd0);
      tick();
      applyStimulus(1'b0, 4'h0, 32'hFFFF_0000, 32'h0);
      axi.rvalid = 1'b1;
      axi.rid    = 4'd1;
      axi.rdata  = 32'hDEAD_BEEF;
      axi.rlast  = 1'b1;
      #1;
      checkOutput("rd_arvalid", 32'(axi.arvalid), 32'd1);
      checkOutput("rd_araddr", axi.araddr, 32'h1000_0004);
      checkOutput("rd_arid", 32'(axi.arid), 32'd1);
      checkOutput("rd_ar_no_fwd", 32'(up_rvalid), 32'd0);
      tick();
      axi.arready = 1'b0;
      #1;
      checkOutput("rd_rready", 32'(axi.rready), 32'd1);
      checkOutput("rd_up_rvalid", 32'(up_rvalid), 32'd1);
      checkOutput("rd_up_rdata", up_rdata, 32'hDEAD_BEEF);
      checkOutput("rd_arvalid_done", 32'(axi.arvalid), 32'd0);
      tick();
      #1;
      checkOutput("rd_back_idle_rready", 32'(axi.rready), 32'd0);
      checkOutput("rd_back_idle_rvalid", 32'(up_rvalid), 32'd0);
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      tick();

      $display("[TB] write with delayed awready");
      applyStimulus(1'b0, 4'hF, 32'hBFAF_F000, 32'h1234_5678);
      tick();
      applyStimulus(1'b0, 4'h0, 32'hDEAD_0000, 32'h1234_5678);
      #1;
      checkOutput("wr_awvalid_1", 32'(axi.awvalid), 32'd1);
      checkOutput("wr_awaddr", axi.awaddr, 32'hBFAF_F000);
      checkOutput("wr_wb_early", 32'(write_begin), 32'd0);
      tick();
      #1;
      checkOutput("wr_awvalid_2", 32'(axi.awvalid), 32'd1);
      tick();
      axi.awready = 1'b1;
      #1;
      checkOutput("wr_awvalid_3", 32'(axi.awvalid), 32'd1);
      checkOutput("wr_write_begin", 32'(write_begin), 32'd1);
      tick();
      axi.awready = 1'b0;
      up_wdata    = 32'h0;
      up_wvalid   = 1'b1;
      up_wlast    = 1'b1;
      #1;
      checkOutput("wr_wb_pulse_end", 32'(write_begin), 32'd0);
      checkOutput("wr_awvalid_drop", 32'(axi.awvalid), 32'd0);
      checkOutput("wr_wvalid", 32'(axi.wvalid), 32'd1);
      checkOutput("wr_wdata", axi.wdata, 32'h1234_5678);
      checkOutput("wr_wlast", 32'(axi.wlast), 32'd1);
      checkOutput("wr_wstrb", 32'(axi.wstrb), 32'hF);
      checkOutput("wr_up_wready_lo", 32'(up_wready), 32'd0);
      tick();
      axi.wready = 1'b1;
      #1;
      checkOutput("wr_up_wready_hi", 32'(up_wready), 32'd1);
      tick();
      axi.wready = 1'b0;
      up_wvalid  = 1'b0;
      up_wlast   = 1'b0;
      #1;
      checkOutput("wr_bready", 32'(axi.bready), 32'd1);
      checkOutput("wr_bvalid_wait", 32'(up_bvalid), 32'd0);
      axi.bvalid = 1'b1;
      axi.bid    = 4'd1;
      #1;
      checkOutput("wr_up_bvalid", 32'(up_bvalid), 32'd1);
      tick();
      axi.bvalid = 1'b0;
      #1;
      checkOutput("wr_idle_bready", 32'(axi.bready), 32'd0);
      tick();

      $display("[TB] simultaneous read and write, then mismatched IDs");
      applyStimulus(1'b1, 4'b0011, 32'h1FD0_0020, 32'hCAFE_F00D);
      tick();
      applyStimulus(1'b1, 4'h0, 32'h1FD0_0020, 32'hCAFE_F00D);
      #1;
      checkOutput("both_awvalid", 32'(axi.awvalid), 32'd1);
      checkOutput("both_arvalid", 32'(axi.arvalid), 32'd0);
      checkOutput("both_awsize", 32'(axi.awsize), 32'h2);
      checkOutput("both_awlen", 32'(axi.awlen), 32'h0);
      checkOutput("both_awburst", 32'(axi.awburst), 32'h1);
      axi.awready = 1'b1;
      tick();
      axi.awready = 1'b0;
      up_wvalid   = 1'b1;
      up_wlast    = 1'b1;
      axi.wready  = 1'b1;
      #1;
      checkOutput("both_wstrb", 32'(axi.wstrb), 32'h3);
      checkOutput("both_wdata", axi.wdata, 32'hCAFE_F00D);
      checkOutput("both_arvalid_w", 32'(axi.arvalid), 32'd0);
      tick();
      axi.wready = 1'b0;
      up_wvalid  = 1'b0;
      up_wlast   = 1'b0;
      axi.bvalid = 1'b1;
      axi.bid    = 4'd2;
      #1;
      checkOutput("bad_bid_bvalid", 32'(up_bvalid), 32'd0);
      tick();
      axi.bid = 4'd1;
      #1;
      checkOutput("bad_bid_stay_b", 32'(axi.bready), 32'd1);
      checkOutput("good_bid_bvalid", 32'(up_bvalid), 32'd1);
      tick();
      axi.bvalid = 1'b0;
      #1;
      checkOutput("both_idle_arvalid", 32'(axi.arvalid), 32'd0);
      tick();
      #1;
      checkOutput("both_arvalid_late", 32'(axi.arvalid), 32'd1);
      checkOutput("both_araddr", axi.araddr, 32'h1FD0_0020);
      axi.arready = 1'b1;
      tick();
      axi.arready = 1'b0;
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0);
      axi.rvalid = 1'b1;
      axi.rid    = 4'd2;
      axi.rlast  = 1'b1;
      axi.rdata  = 32'hAAAA_AAAA;
      #1;
      checkOutput("bad_rid_rvalid", 32'(up_rvalid), 32'd0);
      checkOutput("bad_rid_rready", 32'(axi.rready), 32'd1);
      tick();
      #1;
      checkOutput("bad_rid_stay_r", 32'(axi.rready), 32'd1);
      axi.rid   = 4'd1;
      axi.rdata = 32'h5555_5555;
      #1;
      checkOutput("good_rid_rvalid", 32'(up_rvalid), 32'd1);
      checkOutput("good_rid_rdata", up_rdata, 32'h5555_5555);
      checkOutput("good_rid_rid", 32'(up_rid), 32'd1);
      checkOutput("good_rid_rlast", 32'(up_rlast), 32'd1);
      tick();
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      #1;
      checkOutput("rid_idle_rready", 32'(axi.rready), 32'd0);
      tick();

      $display("[TB] async reset during W");
      applyStimulus(1'b0, 4'hF, 32'h0000_1230, 32'h8765_4321);
      tick();
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h8765_4321);
      axi.awready = 1'b1;
      tick();
      axi.awready = 1'b0;
      up_wvalid   = 1'b1;
      up_wlast    = 1'b1;
      #1;
      checkOutput("pre_rst_wvalid", 32'(axi.wvalid), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("async_rst_wvalid", 32'(axi.wvalid), 32'd0);
      checkOutput("async_rst_wlast", 32'(axi.wlast), 32'd0);
      checkOutput("async_rst_wdata", axi.wdata, 32'h0);
      checkOutput("async_rst_wstrb", 32'(axi.wstrb), 32'h0);
      checkOutput("async_rst_awaddr", axi.awaddr, 32'h0);
      tick();
      rst       = 1'b1;
      up_wvalid = 1'b0;
      up_wlast  = 1'b0;
      tick();
      #1;
      checkOutput("post_rst_awvalid", 32'(axi.awvalid), 32'd0);
      checkOutput("post_rst_wvalid", 32'(axi.wvalid), 32'd0);
      applyStimulus(1'b1, 4'h0, 32'h0000_0044, 32'h0);
      tick();
      #1;
      checkOutput("post_rst_arvalid", 32'(axi.arvalid), 32'd1);
      checkOutput("post_rst_araddr", axi.araddr, 32'h0000_0044);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/confreg_axi_bridge.md
Name: confreg_axi_bridge

Overview:
- Downstream of the CPU-side uncached/confreg access FSM; converts its single-word request/response signalling into AXI3 master channels (AR/R/AW/W/B).
- One outstanding transaction at a time, single beat, 4-byte size.
- Returns `write_begin`, `rvalid`/`rid`/`rlast`/`rdata`, `wready` and `bvalid` to the upstream FSM.

Parameters:
- ID_W, 4, AXI ID width
- RD_ID, 4'b0001, ARID driven; R beats only forwarded when RID==RD_ID
- WR_ID, 4'b0001, AWID/WID driven; B only accepted when BID==WR_ID

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- up_rd_req  in  1  read request (held until response)
- up_wr_strb  in  4  byte strobes; nonzero = write request (priority over read)
- up_addr  in  32  word address
- up_wdata  in  32  write data
- up_wvalid  in  1  upstream data-phase valid
- up_wlast  in  1  upstream last flag
- write_begin  out  1  one-cycle pulse on AW handshake
- up_rvalid  out  1  forwarded read beat valid
- up_rid  out  ID_W  forwarded RID
- up_rlast  out  1  forwarded RLAST
- up_rdata  out  32  forwarded RDATA
- up_wready  out  1  forwarded WREADY
- up_bvalid  out  1  write response to upstream
- arid/awid/wid  out  ID_W each  RD_ID / WR_ID / WR_ID
- araddr/awaddr  out  32 each  latched address
- arlen/awlen  out  4 each  constant 0
- arsize/awsize  out  3 each  constant 3'b010
- arburst/awburst  out  2 each  constant 2'b01
- arlock/awlock  out  2 each  constant 0
- arcache/awcache  out  4 each  constant 0
- arprot/awprot  out  3 each  constant 0
- arvalid, awvalid  out  1 each
- arready, awready  in  1 each
- rid  in  ID_W; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1
- rready  out  1
- wdata  out  32; wstrb  out  4; wlast  out  1; wvalid  out  1
- wready  in  1
- bid  in  ID_W; bresp  in  2; bvalid  in  1
- bready  out  1

Behaviour:
- States:
  - IDLE: if up_wr_strb!=0, latch addr/strb, go AW. Else if up_rd_req, latch addr, go AR.
  - AR: arvalid=1; on arready go R.
  - R: rready=1. up_rvalid = rvalid & rid==RD_ID; up_rid/up_rlast/up_rdata = rid/rlast/rdata. On rvalid & rid==RD_ID & rlast go IDLE. Mismatched IDs are consumed and dropped.
  - AW: awvalid=1; on awready pulse write_begin, latch up_wdata, go W.
  - W: wvalid = up_wvalid; wlast = up_wlast; wdata = latched data; wstrb = latched strb; up_wready = wready. On wvalid & wready go B.
  - B: bready=1. On bvalid & bid==WR_ID: up_bvalid=1 same cycle, go IDLE. Mismatched B is consumed and ignored.
- All handshake outputs are 0 outside their state; up_rvalid/up_wready/up_bvalid/write_begin are combinational in their states.
- arvalid/awvalid, once asserted, stay high until handshake (AXI rule). Address/strb are stable from request latch to handshake, even if upstream deasserts.
- Latency: request in IDLE → arvalid/awvalid next cycle. A zero-wait slave yields a read in 3 cycles from request.
- Simultaneous read and write request in IDLE: write wins; read stays pending upstream.
- New requests are ignored outside IDLE.
- rresp/bresp are ignored (data forwarded regardless).
- Reset (async, any state): state=IDLE; all valid/ready/pulse outputs 0; latched addr/data/strb 0; upstream outputs 0.

Decomposition:
- Shared package: state encoding (IDLE/AR/R/AW/W/B), AXI constants (SIZE_4B=3'b010, BURST_INCR=2'b01, LEN_1=0), default IDs.
- No sub-module; single FSM plus latch registers.

Test Plan:
- Read, arready=1 immediately, R beat rid=1 rdata=32'hDEADBEEF rlast=1 → araddr=up_addr; up_rvalid high 1 cycle with data DEADBEEF; state back to IDLE.
- Write strb=4'b1111 addr=32'hBFAF_F000 data=32'h12345678, awready delayed 3 cycles → awvalid held 3 cycles, write_begin 1-cycle pulse, wdata=12345678 wlast=1, up_bvalid on bvalid bid=1.
- Read and write requested same cycle → awvalid first, arvalid only after the write completes.
- R beat with rid=2 then rid=1 → first beat not forwarded, no exit; second forwarded.
- Async reset asserted in W state with wvalid high → all outputs 0 immediately; IDLE after release.
- Write strb=4'b0011 → wstrb=0011, awsize=010, awlen=0.
